// File: rtl/arb_pkg.sv
// Shared types and default widths for the single-port IF/LSU memory arbiter.
package arb_pkg;

  localparam int unsigned ARB_ADDR_W      = 32;
  localparam int unsigned ARB_DATA_W      = 32;
  localparam int unsigned ARB_STARVE_MAX  = 4;
  localparam int unsigned ARB_TIMEOUT_CYC = 255;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_LSU
  } arb_owner_e;

endpackage

// File: rtl/arb_watchdog.sv
// Transaction watchdog: counts cycles while a transaction is outstanding and
// flags expiry on the TIMEOUT_CYC-th cycle. Only instantiated under ARB_TIMEOUT_EN.
module arb_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic active_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired_o = active_i && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (!active_i) begin
      cnt_d = '0;
    end else if (!expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates the IF fetch and the LSU onto one memory port, one transaction at a time.
// Optional watchdog timeout enabled by defining ARB_TIMEOUT_EN.
module imem_dmem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = ARB_ADDR_W,
  parameter int unsigned DATA_W      = ARB_DATA_W,
  parameter int unsigned STARVE_MAX  = ARB_STARVE_MAX,
  parameter int unsigned TIMEOUT_CYC = ARB_TIMEOUT_CYC
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  input  logic                i_if_flush,
  output logic [DATA_W-1:0]   o_if_rdata,
  output logic                o_if_rvalid,
  output logic                o_if_stall,
  input  logic                i_lsu_req,
  input  logic                i_lsu_wren,
  input  logic [ADDR_W-1:0]   i_lsu_addr,
  input  logic [DATA_W-1:0]   i_lsu_wdata,
  input  logic [DATA_W/8-1:0] i_lsu_bmask,
  output logic [DATA_W-1:0]   o_lsu_rdata,
  output logic                o_lsu_done,
  output logic                o_lsu_stall,
  output logic                o_mem_req,
  output logic                o_mem_wren,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_bmask,
  input  logic                i_mem_gnt,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_err
);

  localparam int unsigned BmW     = DATA_W / 8;
  localparam int unsigned StreakW = $clog2(STARVE_MAX + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(STARVE_MAX);

  arb_state_e          state_q, state_d;
  arb_owner_e          owner_q, owner_d;
  logic                kill_q, kill_d;
  logic [StreakW-1:0]  streak_q, streak_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_wren_q, mem_wren_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BmW-1:0]      mem_bmask_q, mem_bmask_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;
  logic                err_q, err_d;

  logic grant_if, grant_lsu, timeout, wd_active, if_resp_ok, lsu_resp;

  // A flush in the same cycle blocks the IF grant so the stale address never issues.
  assign grant_if  = i_if_req && !i_if_flush && (!i_lsu_req || (streak_q == StreakMax));
  assign grant_lsu = i_lsu_req && !grant_if;
  assign wd_active = (state_q == ISSUE) || (state_q == WAIT);

`ifdef ARB_TIMEOUT_EN
  arb_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk_i    (i_clk),
    .rst_ni   (i_reset),
    .active_i (wd_active),
    .expired_o(timeout)
  );
  assign o_err = err_q;
`else
  assign timeout = 1'b0;
  assign o_err   = 1'b0;
  logic unused_wd;
  assign unused_wd = err_q ^ wd_active ^ (^TIMEOUT_CYC);
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    kill_d      = kill_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_wren_d  = mem_wren_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_bmask_d = mem_bmask_q;
    rdata_d     = rdata_q;
    if_rdata_d  = if_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
    err_d       = 1'b0;

    if (!i_if_req) begin
      streak_d = '0;
    end else if (state_q == IDLE && grant_if) begin
      streak_d = '0;
    end else if (state_q == IDLE && grant_lsu && streak_q != StreakMax) begin
      streak_d = streak_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (grant_lsu) begin
          owner_d     = OWN_LSU;
          mem_req_d   = 1'b1;
          mem_wren_d  = i_lsu_wren;
          mem_addr_d  = i_lsu_addr;
          mem_wdata_d = i_lsu_wdata;
          mem_bmask_d = i_lsu_bmask;
          state_d     = ISSUE;
        end else if (grant_if) begin
          owner_d     = OWN_IF;
          mem_req_d   = 1'b1;
          mem_wren_d  = 1'b0;
          mem_addr_d  = i_if_addr;
          mem_wdata_d = '0;
          mem_bmask_d = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        if (i_if_flush && owner_q == OWN_IF) kill_d = 1'b1;
        if (state_q == ISSUE && i_mem_gnt) begin
          mem_req_d = 1'b0;
          if (i_mem_rvalid) begin
            rdata_d = i_mem_rdata;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end else if (state_q == WAIT && i_mem_rvalid) begin
          rdata_d = i_mem_rdata;
          state_d = RESP;
        end else if (timeout) begin
          mem_req_d = 1'b0;
          rdata_d   = '0;
          err_d     = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (if_resp_ok) if_rdata_d = rdata_q;
        if (lsu_resp) lsu_rdata_d = rdata_q;
        kill_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      kill_q      <= 1'b0;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_bmask_q <= '0;
      rdata_q     <= '0;
      if_rdata_q  <= '0;
      lsu_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      kill_q      <= kill_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_wren_q  <= mem_wren_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_bmask_q <= mem_bmask_d;
      rdata_q     <= rdata_d;
      if_rdata_q  <= if_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
      err_q       <= err_d;
    end
  end

  // A flush landing in the RESP cycle itself still suppresses the fetch result.
  assign if_resp_ok = (state_q == RESP) && (owner_q == OWN_IF) && !kill_q && !i_if_flush;
  assign lsu_resp   = (state_q == RESP) && (owner_q == OWN_LSU);

  assign o_if_rvalid = if_resp_ok;
  assign o_if_rdata  = if_resp_ok ? rdata_q : if_rdata_q;
  assign o_lsu_done  = lsu_resp;
  assign o_lsu_rdata = lsu_resp ? rdata_q : lsu_rdata_q;
  assign o_if_stall  = i_if_req & ~o_if_rvalid;
  assign o_lsu_stall = i_lsu_req & ~o_lsu_done;

  assign o_mem_req   = mem_req_q;
  assign o_mem_wren  = mem_wren_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_bmask = mem_bmask_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed self-checking bench for imem_dmem_arbiter; the timeout scenario is
// built only when ARB_TIMEOUT_EN is defined (TIMEOUT_CYC overridden to 8).
module tb_imem_dmem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_if_req = 1'b0;
  logic [31:0] i_if_addr = '0;
  logic        i_if_flush = 1'b0;
  logic [31:0] o_if_rdata;
  logic        o_if_rvalid;
  logic        o_if_stall;
  logic        i_lsu_req = 1'b0;
  logic        i_lsu_wren = 1'b0;
  logic [31:0] i_lsu_addr = '0;
  logic [31:0] i_lsu_wdata = '0;
  logic [3:0]  i_lsu_bmask = '0;
  logic [31:0] o_lsu_rdata;
  logic        o_lsu_done;
  logic        o_lsu_stall;
  logic        o_mem_req;
  logic        o_mem_wren;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        i_mem_gnt = 1'b0;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_err;

  int n_checks = 0;
  int n_fail = 0;

  imem_dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT_CYC(8)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
    .o_if_rdata(o_if_rdata), .o_if_rvalid(o_if_rvalid), .o_if_stall(o_if_stall),
    .i_lsu_req(i_lsu_req), .i_lsu_wren(i_lsu_wren), .i_lsu_addr(i_lsu_addr),
    .i_lsu_wdata(i_lsu_wdata), .i_lsu_bmask(i_lsu_bmask), .o_lsu_rdata(o_lsu_rdata),
    .o_lsu_done(o_lsu_done), .o_lsu_stall(o_lsu_stall),
    .o_mem_req(o_mem_req), .o_mem_wren(o_mem_wren), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
    .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge i_clk);
  endtask

  // Memory side of one transaction: wait for a request, grant it, answer next cycle.
  // Returns in the RESP cycle.
  task automatic serve(input logic [31:0] data, output logic [31:0] addr, output logic ok);
    int n = 0;
    addr = '0;
    ok = 1'b1;
    while (!o_mem_req && n < 8) begin
      tick();
      n++;
    end
    if (!o_mem_req) begin
      ok = 1'b0;
      return;
    end
    addr = o_mem_addr;
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata = data;
    tick();
    i_mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({o_mem_req, o_mem_wren, o_if_rvalid, o_lsu_done, o_err, o_if_stall, o_lsu_stall} !== 7'b0)
    begin
      n_fail++;
      $display("FAIL reset_ctrl: got req=%b wren=%b ifv=%b done=%b err=%b ifs=%b lss=%b, want 0",
               o_mem_req, o_mem_wren, o_if_rvalid, o_lsu_done, o_err, o_if_stall, o_lsu_stall);
    end
    n_checks++;
    if ({o_mem_addr, o_mem_wdata, o_mem_bmask, o_if_rdata, o_lsu_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h wdata=%h bm=%h ifd=%h lsd=%h, want 0",
               o_mem_addr, o_mem_wdata, o_mem_bmask, o_if_rdata, o_lsu_rdata);
    end
    i_reset = 1'b1;
    tick();
    n_checks++;
    if (o_mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: o_mem_req=%b, want 0", o_mem_req);
    end
  endtask

  task automatic test_if_read();
    i_if_req = 1'b1;
    i_if_addr = 32'h0000_0010;
    tick();
    n_checks++;
    if ({o_mem_req, o_mem_wren, o_mem_addr, o_if_stall} !== {1'b1, 1'b0, 32'h10, 1'b1}) begin
      n_fail++;
      $display("FAIL if_issue: req=%b wren=%b addr=%h stall=%b, want 1 0 00000010 1",
               o_mem_req, o_mem_wren, o_mem_addr, o_if_stall);
    end
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0;
    n_checks++;
    if (o_mem_req !== 1'b0 || o_if_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL if_wait: req=%b rvalid=%b, want 0 0", o_mem_req, o_if_rvalid);
    end
    i_mem_rvalid = 1'b1;
    i_mem_rdata = 32'h0050_0093;
    tick();
    i_mem_rvalid = 1'b0;
    n_checks++;
    if ({o_if_rvalid, o_if_rdata, o_lsu_done, o_if_stall, o_err}
        !== {1'b1, 32'h0050_0093, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL if_resp: rvalid=%b rdata=%h done=%b stall=%b err=%b, want 1 00500093 0 0 0",
               o_if_rvalid, o_if_rdata, o_lsu_done, o_if_stall, o_err);
    end
    i_if_req = 1'b0;
    tick();
    n_checks++;
    if (o_if_rvalid !== 1'b0 || o_if_rdata !== 32'h0050_0093 || o_lsu_done !== 1'b0) begin
      n_fail++;
      $display("FAIL if_hold: rvalid=%b rdata=%h done=%b, want 0 00500093 0",
               o_if_rvalid, o_if_rdata, o_lsu_done);
    end
  endtask

  task automatic test_both_store();
    i_if_req = 1'b1;
    i_if_addr = 32'h0000_0100;
    i_lsu_req = 1'b1;
    i_lsu_wren = 1'b1;
    i_lsu_addr = 32'h0000_2000;
    i_lsu_wdata = 32'hDEAD_BEEF;
    i_lsu_bmask = 4'b1111;
    tick();
    n_checks++;
    if ({o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_bmask, o_if_stall, o_lsu_stall}
        !== {1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL both_lsu_first: req=%b wren=%b addr=%h wd=%h bm=%h ifs=%b lss=%b",
               o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_bmask,
               o_if_stall, o_lsu_stall);
    end
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata = 32'h0;
    tick();
    i_mem_rvalid = 1'b0;
    n_checks++;
    if ({o_lsu_done, o_if_rvalid, o_lsu_stall} !== 3'b100) begin
      n_fail++;
      $display("FAIL both_store_done: done=%b ifv=%b lss=%b, want 1 0 0",
               o_lsu_done, o_if_rvalid, o_lsu_stall);
    end
    i_lsu_req = 1'b0;
    i_lsu_wren = 1'b0;
    tick();
    n_checks++;
    if (o_mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL both_idle_gap: o_mem_req=%b, want 0", o_mem_req);
    end
    tick();
    n_checks++;
    if ({o_mem_req, o_mem_wren, o_mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
      n_fail++;
      $display("FAIL both_if_second: req=%b wren=%b addr=%h, want 1 0 00000100",
               o_mem_req, o_mem_wren, o_mem_addr);
    end
    // Grant and response in the same cycle skip WAIT.
    i_mem_gnt = 1'b1;
    i_mem_rvalid = 1'b1;
    i_mem_rdata = 32'h1234_5678;
    tick();
    i_mem_gnt = 1'b0;
    i_mem_rvalid = 1'b0;
    n_checks++;
    if (o_if_rvalid !== 1'b1 || o_if_rdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL both_if_fast: rvalid=%b rdata=%h, want 1 12345678", o_if_rvalid, o_if_rdata);
    end
    i_if_req = 1'b0;
    tick();
  endtask

  task automatic test_starve();
    logic [31:0] a;
    logic ok;
    logic [5:0] seq;
    seq = '0;
    i_lsu_req = 1'b1;
    i_lsu_wren = 1'b0;
    i_lsu_addr = 32'h0000_4000;
    i_if_req = 1'b1;
    i_if_addr = 32'h0000_0080;
    for (int t = 0; t < 6; t++) begin
      serve(32'h100 + t, a, ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL starve_req_%0d: no memory request within bound, want request", t);
      end
      seq[t] = (a == 32'h80);
      n_checks++;
      if (seq[t]) begin
        if (o_if_rvalid !== 1'b1 || o_if_rdata !== 32'h100 + t) begin
          n_fail++;
          $display("FAIL starve_if_%0d: rvalid=%b rdata=%h, want 1 %h",
                   t, o_if_rvalid, o_if_rdata, 32'h100 + t);
        end
        i_if_req = 1'b0;
      end else if (o_lsu_done !== 1'b1 || o_lsu_rdata !== 32'h100 + t) begin
        n_fail++;
        $display("FAIL starve_lsu_%0d: done=%b rdata=%h, want 1 %h",
                 t, o_lsu_done, o_lsu_rdata, 32'h100 + t);
      end
      if (t == 5) i_lsu_req = 1'b0;
    end
    tick();
    n_checks++;
    if (seq !== 6'b010000) begin
      n_fail++;
      $display("FAIL starve_order: IF-grant pattern=%b, want 010000", seq);
    end
  endtask

  task automatic test_flush();
    logic [31:0] a;
    logic ok;
    i_if_req = 1'b1;
    i_if_addr = 32'h0000_0020;
    serve(32'h0ACE_0001, a, ok);
    i_if_req = 1'b0;
    tick();
    // Flush coincident with the IF grant: nothing issues that cycle.
    i_if_req = 1'b1;
    i_if_addr = 32'h0000_0030;
    i_if_flush = 1'b1;
    tick();
    i_if_flush = 1'b0;
    n_checks++;
    if (o_mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_grant: o_mem_req=%b, want 0", o_mem_req);
    end
    tick();
    n_checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h30) begin
      n_fail++;
      $display("FAIL flush_issue: req=%b addr=%h, want 1 00000030", o_mem_req, o_mem_addr);
    end
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0;
    i_if_flush = 1'b1;
    i_if_addr = 32'h0000_0040;
    tick();
    i_if_flush = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata = 32'h1111_1111;
    tick();
    i_mem_rvalid = 1'b0;
    n_checks++;
    if ({o_if_rvalid, o_if_rdata, o_if_stall} !== {1'b0, 32'h0ACE_0001, 1'b1}) begin
      n_fail++;
      $display("FAIL flush_kill: rvalid=%b rdata=%h stall=%b, want 0 0ace0001 1",
               o_if_rvalid, o_if_rdata, o_if_stall);
    end
    serve(32'h2222_2222, a, ok);
    n_checks++;
    if (!ok || a !== 32'h40 || o_if_rvalid !== 1'b1 || o_if_rdata !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL flush_refetch: ok=%b addr=%h rvalid=%b rdata=%h, want 1 00000040 1 22222222",
               ok, a, o_if_rvalid, o_if_rdata);
    end
    i_if_req = 1'b0;
    tick();
  endtask

  task automatic test_hold_reset();
    i_lsu_req = 1'b1;
    i_lsu_wren = 1'b1;
    i_lsu_addr = 32'h0000_3000;
    i_lsu_wdata = 32'hCAFE_F00D;
    i_lsu_bmask = 4'b0101;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_bmask}
          !== {1'b1, 1'b1, 32'h3000, 32'hCAFE_F00D, 4'b0101}) begin
        n_fail++;
        $display("FAIL hold_stable_%0d: req=%b wren=%b addr=%h wd=%h bm=%b", i,
                 o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_bmask);
      end
      tick();
    end
    i_lsu_req = 1'b0;
    i_lsu_wren = 1'b0;
    i_reset = 1'b0;
    #1;
    n_checks++;
    if ({o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_bmask, o_lsu_done,
         o_if_rvalid, o_err, o_if_rdata, o_lsu_rdata, o_if_stall, o_lsu_stall} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: req=%b wren=%b addr=%h wd=%h bm=%b ifd=%h lsd=%h, want 0",
               o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_bmask,
               o_if_rdata, o_lsu_rdata);
    end
    tick();
    i_reset = 1'b1;
    tick();
    n_checks++;
    if (o_mem_req !== 1'b0 || o_lsu_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: req=%b done=%b, want 0 0", o_mem_req, o_lsu_done);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    i_if_req = 1'b1;
    i_if_addr = 32'h0000_0050;
    tick();
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0;
    for (int k = 1; k < 8; k++) begin
      n_checks++;
      if (o_if_rvalid !== 1'b0 || o_err !== 1'b0) begin
        n_fail++;
        $display("FAIL tmo_early_%0d: rvalid=%b err=%b, want 0 0", k, o_if_rvalid, o_err);
      end
      tick();
    end
    n_checks++;
    if ({o_if_rvalid, o_if_rdata, o_err, o_mem_req} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL tmo_resp: rvalid=%b rdata=%h err=%b req=%b, want 1 00000000 1 0",
               o_if_rvalid, o_if_rdata, o_err, o_mem_req);
    end
    i_if_req = 1'b0;
    tick();
    n_checks++;
    if (o_err !== 1'b0 || o_if_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_after: err=%b rvalid=%b, want 0 0", o_err, o_if_rvalid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_if_read();
    test_both_store();
    test_starve();
    test_flush();
    test_hold_reset();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
